ppu_out_packer: RTL and testbench

Downstream neighbour of the PPU. Collects the PPU's registered 8-bit quantised outputs (byte plus valid strobe), packs four consecutive bytes little-endian into one 32-bit word, and writes the words to the output global buffer at consecutive word addresses. The PPU cannot be stalled, so a small word FIFO absorbs write-port backpressure. A start/done handshake with the controller frames each output tile.

---
 rtl/ppu_out_packer.sv | 201 ++++++++++++++++++++
 tb/tb_ppu_out_packer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_out_packer.sv
// ppu_out_packer: gathers the PPU's 8-bit outputs into 32-bit little-endian
// words and writes them to consecutive global-buffer word addresses. The PPU
// cannot be stalled, so a small word FIFO sits between the packer and the
// write port. A start/done handshake frames each output tile.
//
// Handshake (write port): a word is transferred in every cycle where
// wr_en & wr_ready are both high. wr_en means "the FIFO holds a word";
// wr_addr and wr_data show that word and hold still until it is taken.
// Both read as zero while wr_en is low.
module ppu_out_packer #(
    parameter int DATA_BITS  = 32,
    parameter int ADDR_BITS  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS-1:0] num_bytes,
    input  logic                 i_valid,
    input  logic [7:0]           i_data,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [DATA_BITS-1:0] wr_data,
    input  logic                 wr_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [1:0]           fsm_state
);

    localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PACK  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS-1:0] ADDR_ZERO = '0;
    localparam logic [PTR_BITS:0]    CNT_FULL = (PTR_BITS+1)'(FIFO_DEPTH);
    localparam logic [PTR_BITS:0]    CNT_ONE  = {{PTR_BITS{1'b0}}, 1'b1};
    localparam logic [PTR_BITS-1:0]  PTR_ONE  = {{(PTR_BITS-1){1'b0}}, 1'b1};

    // Tile parameters and progress counters
    logic [1:0]           state;
    logic [ADDR_BITS-1:0] base_q;
    logic [ADDR_BITS-1:0] num_q;
    logic [ADDR_BITS-1:0] byte_cnt;
    logic [ADDR_BITS-1:0] word_cnt;
    logic [DATA_BITS-1:0] pack_reg;
    logic                 overflow_q;

    // Word FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]  rd_ptr;
    logic [PTR_BITS-1:0]  wr_ptr;
    logic [PTR_BITS:0]    count;
    logic [PTR_BITS:0]    count_next;

    // Combinational helpers
    logic [1:0]           lane;
    logic                 accept_byte;
    logic                 last_byte;
    logic                 push;
    logic                 push_ok;
    logic                 drop;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [DATA_BITS-1:0] merged;

    assign lane        = byte_cnt[1:0];
    assign accept_byte = (state == S_PACK) && i_valid;
    assign last_byte   = (byte_cnt == (num_q - ADDR_ONE));
    assign push        = accept_byte && ((lane == 2'd3) || last_byte);
    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CNT_FULL);
    assign pop         = !fifo_empty && wr_ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push_ok     = push && (!fifo_full || pop);
    assign drop        = push && fifo_full && !pop;

    // Insert the incoming byte into its lane of the partially built word
    always_comb begin
        merged = pack_reg;
        merged[{lane, 3'b000} +: 8] = i_data;
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + CNT_ONE;
        end else if (!push_ok && pop) begin
            count_next = count - CNT_ONE;
        end
    end

    // Control FSM, tile registers, byte packing and overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            byte_cnt   <= '0;
            pack_reg   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        num_q      <= num_bytes;
                        byte_cnt   <= '0;
                        pack_reg   <= '0;
                        overflow_q <= 1'b0;
                        state      <= (num_bytes == ADDR_ZERO) ? S_DONE : S_PACK;
                    end
                end
                S_PACK: begin
                    if (accept_byte) begin
                        byte_cnt <= byte_cnt + ADDR_ONE;
                        // Clearing after a push leaves unwritten upper lanes
                        // of a short final word at zero.
                        pack_reg <= push ? '0 : merged;
                        if (drop) begin
                            overflow_q <= 1'b1;
                        end
                        if (last_byte) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (count_next == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Word counter advances on every accepted write; cleared by start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            word_cnt <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + ADDR_ONE;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
        end
    end

    // FIFO storage; contents are meaningless while the count is zero
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= merged;
        end
    end

    // Write port: head of FIFO at base + words already written (wraps)
    always_comb begin
        wr_en   = !fifo_empty;
        wr_data = '0;
        wr_addr = '0;
        if (!fifo_empty) begin
            wr_data = mem[rd_ptr];
            wr_addr = base_q + word_cnt;
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign overflow  = overflow_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_ppu_out_packer.sv
// Bench for ppu_out_packer: directed tiles with hand-computed expected
// writes pushed to a queue; a negedge monitor pops and compares each
// accepted write and checks that stalled writes hold still.
module tb_ppu_out_packer;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int W  = AW + DW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_bytes;
    logic          i_valid;
    logic [7:0]    i_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [1:0]    fsm_state;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    logic [W-1:0] exp_q[$];

    logic         prev_stall;
    logic [W-1:0] prev_word;

    ppu_out_packer #(.DATA_BITS(DW), .ADDR_BITS(AW), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_bytes (num_bytes),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .fsm_state (fsm_state)
    );

    // Clock and global time limit
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare accepted writes against the queue, check stall hold
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_wr_en", W'(wr_en), W'(1));
                check("stall_hold", {wr_addr, wr_data}, prev_word);
            end
            if (wr_en && wr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                             wr_addr, wr_data);
                end else begin
                    check("write", {wr_addr, wr_data}, exp_q.pop_front());
                end
            end
            if (done) done_cnt++;
            prev_stall = wr_en && !wr_ready;
            prev_word  = {wr_addr, wr_data};
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
        start     = 1'b1;
        base_addr = b;
        num_bytes = n;
        step();
        start     = 1'b0;
        base_addr = '0;
        num_bytes = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_valid = 1'b1;
        i_data  = b;
        step();
        i_valid = 1'b0;
        i_data  = '0;
    endtask

    task automatic send_range(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) send_byte(first + 8'(i));
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Wait for done (bounded), then check the done/busy tail and the queue
    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        int d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: done=0 after %0d cycles, expected 1", name, budget);
        end else begin
            check({name, "_busy_at_done"}, W'(busy), W'(1));
            @(negedge clk);
            check({name, "_done_pulse"}, W'(done), W'(0));
            check({name, "_busy_fall"}, W'(busy), W'(0));
            check({name, "_done_count"}, W'(done_cnt - d0), W'(1));
        end
        check({name, "_queue_empty"}, W'(exp_q.size()), W'(0));
        step();
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_wr_en"}, W'(wr_en), W'(0));
        check({name, "_wr_addr"}, W'(wr_addr), W'(0));
        check({name, "_wr_data"}, W'(wr_data), W'(0));
        check({name, "_busy"}, W'(busy), W'(0));
        check({name, "_done"}, W'(done), W'(0));
        check({name, "_overflow"}, W'(overflow), W'(0));
        check({name, "_state"}, W'(fsm_state), W'(0));
    endtask

    // Directed test sequence
    initial begin
        rst = 1'b0; start = 1'b0; base_addr = '0; num_bytes = '0;
        i_valid = 1'b0; i_data = '0; wr_ready = 1'b1;
        prev_stall = 1'b0; prev_word = '0;
        repeat (3) step();
        check_idle_outputs("reset");
        rst = 1'b1;
        step();
        check_idle_outputs("after_reset");

        // Continuous stream
        wr_ready = 1'b1;
        push_exp(16'h0100, 32'h04030201);
        push_exp(16'h0101, 32'h08070605);
        do_start(16'h0100, 16'd8);
        check("cont_busy", W'(busy), W'(1));
        send_range(8'h01, 8);
        wait_done("cont", 50);
        check("cont_overflow", W'(overflow), W'(0));

        // Partial last word
        push_exp(16'h0200, 32'hDDCCBBAA);
        push_exp(16'h0201, 32'h0000FFEE);
        do_start(16'h0200, 16'd6);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        send_byte(8'hDD); send_byte(8'hEE); send_byte(8'hFF);
        wait_done("partial", 50);

        // Backpressure: exactly fills the FIFO
        wr_ready = 1'b0;
        push_exp(16'h0300, 32'h13121110);
        push_exp(16'h0301, 32'h17161514);
        push_exp(16'h0302, 32'h1B1A1918);
        push_exp(16'h0303, 32'h1F1E1D1C);
        do_start(16'h0300, 16'd16);
        send_range(8'h10, 16);
        repeat (3) step();
        check("bp_overflow", W'(overflow), W'(0));
        check("bp_wr_en", W'(wr_en), W'(1));
        check("bp_head", {wr_addr, wr_data}, {16'h0300, 32'h13121110});
        wr_ready = 1'b1;
        wait_done("bp", 50);

        // Overflow: fifth word dropped
        wr_ready = 1'b0;
        push_exp(16'h0400, 32'h23222120);
        push_exp(16'h0401, 32'h27262524);
        push_exp(16'h0402, 32'h2B2A2928);
        push_exp(16'h0403, 32'h2F2E2D2C);
        do_start(16'h0400, 16'd20);
        send_range(8'h20, 20);
        check("ovf_set", W'(overflow), W'(1));
        repeat (2) step();
        wr_ready = 1'b1;
        wait_done("ovf", 50);
        check("ovf_sticky", W'(overflow), W'(1));

        // Empty tile; start also clears overflow
        do_start(16'h0500, 16'd0);
        check("zero_ovf_clear", W'(overflow), W'(0));
        wait_done("zero", 5);

        // Address wrap
        push_exp(16'hFFFF, 32'h47464544);
        push_exp(16'h0000, 32'h4B4A4948);
        do_start(16'hFFFF, 16'd8);
        send_range(8'h44, 8);
        wait_done("wrap", 50);

        // Start while busy is ignored
        wr_ready = 1'b0;
        push_exp(16'h0600, 32'h53525150);
        do_start(16'h0600, 16'd4);
        do_start(16'h0700, 16'd9);
        send_range(8'h50, 4);
        step();
        wr_ready = 1'b1;
        wait_done("busy_start", 50);

        // Reset mid-tile discards everything asynchronously
        wr_ready = 1'b0;
        do_start(16'h0800, 16'd8);
        send_range(8'h70, 5);
        check("mid_wr_en", W'(wr_en), W'(1));
        #2;
        rst = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        step();
        rst = 1'b1;
        wr_ready = 1'b1;
        step();
        check_idle_outputs("post_reset");
        push_exp(16'h0900, 32'h63626160);
        do_start(16'h0900, 16'd4);
        send_range(8'h60, 4);
        wait_done("restart", 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
